// File: rtl/mispred_tracker_pkg.sv
// Shared core types for branch misprediction tracking: ROB index with wrap
// flag, branch writeback payload, squash payload, tracker FSM states and the
// ROB age comparison.
package mispred_tracker_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned ROB_IDX_W = 6;

  typedef struct packed {
    logic                 flg;
    logic [ROB_IDX_W-1:0] idx;
  } robIdx_t;

  typedef struct packed {
    robIdx_t         rob_idx;
    logic            has_mispred;
    logic            branch_taken;
    logic [XLEN-1:0] branch_npc;
  } branchwbInfo_t;

  typedef struct packed {
    logic            dueToBranch;
    logic            branch_taken;
    logic [XLEN-1:0] arch_pc;
  } squashInfo_t;

  typedef enum logic [1:0] {
    StIdle,
    StPending,
    StSquash,
    StDrain
  } mispred_state_e;

  // True when a is older than b. The wrap flag flips each pass around the
  // ROB, so differing flags invert the index ordering. Equal indices are
  // never compared by callers.
  function automatic logic rob_is_older(robIdx_t a, robIdx_t b);
    return (a.flg == b.flg) ? (a.idx < b.idx) : (a.idx > b.idx);
  endfunction

endpackage

// File: rtl/mispred_tracker_rob_age_select.sv
// rob_age_select: picks the oldest valid ROB index out of N candidates.
// Candidates carry unique ROB indices, so there is never a tie.
module rob_age_select
  import mispred_tracker_pkg::*;
#(
  parameter int unsigned N = 2,
  localparam int unsigned SelW = (N > 1) ? $clog2(N) : 1
) (
  input  logic    [N-1:0]    i_vld,
  input  robIdx_t [N-1:0]    i_idx,
  output logic               o_vld,
  output logic    [SelW-1:0] o_sel
);

  // Linear scan keeping the oldest valid candidate seen so far.
  always_comb begin
    o_vld = 1'b0;
    o_sel = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (i_vld[i] && (!o_vld || rob_is_older(i_idx[i], i_idx[o_sel]))) begin
        o_vld = 1'b1;
        o_sel = SelW'(i);
      end
    end
  end

endmodule

// File: rtl/mispred_tracker.sv
// mispred_tracker: tracks the oldest mispredicted branch written back by the
// BRUs, raises a one-cycle squash when that branch reaches the ROB head, then
// holds busy until rename restore completes.
// Optional feature: define MISPRED_EARLY_REDIRECT_EN to add o_redirect_vld /
// o_redirect_pc, a frontend redirect one cycle after each capture/replacement.
module mispred_tracker
  import mispred_tracker_pkg::*;
#(
  parameter int unsigned NUM_BRU   = 2,
  parameter int unsigned ROB_DEPTH = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic          [NUM_BRU-1:0]  i_wb_vld,
  input  branchwbInfo_t [NUM_BRU-1:0]  i_wb_info,
  input  logic                         i_head_commit,
  input  robIdx_t                      i_head_rob_idx,
  input  logic                         i_ext_flush,
  input  logic                         i_restore_done,
  output logic                         o_squash_vld,
  output squashInfo_t                  o_squash_info,
  output logic                         o_mispred_pending,
  output logic                         o_busy
`ifdef MISPRED_EARLY_REDIRECT_EN
  ,
  output logic                         o_redirect_vld,
  output logic          [XLEN-1:0]     o_redirect_pc
`endif
);

  localparam int unsigned SelW = (NUM_BRU > 1) ? $clog2(NUM_BRU) : 1;

  if (ROB_DEPTH != (1 << ROB_IDX_W)) begin : g_depth_check
    $error("ROB_DEPTH does not match the robIdx_t index width");
  end

  logic          [NUM_BRU-1:0] w_mis_vld;
  robIdx_t       [NUM_BRU-1:0] w_wb_rob;
  logic                        w_sel_vld;
  logic          [SelW-1:0]    w_sel_idx;
  branchwbInfo_t               w_sel_info;

  mispred_state_e              r_state;
  mispred_state_e              w_state_nxt;
  logic                        w_capture;

  robIdx_t                     r_rob_idx;
  logic                        r_taken;
  logic          [XLEN-1:0]    r_npc;

  // Only valid writebacks that actually mispredicted compete for tracking.
  always_comb begin
    for (int unsigned i = 0; i < NUM_BRU; i++) begin
      w_mis_vld[i] = i_wb_vld[i] && i_wb_info[i].has_mispred;
      w_wb_rob[i]  = i_wb_info[i].rob_idx;
    end
  end

  rob_age_select #(
    .N (NUM_BRU)
  ) u_age_select (
    .i_vld (w_mis_vld),
    .i_idx (w_wb_rob),
    .o_vld (w_sel_vld),
    .o_sel (w_sel_idx)
  );

  assign w_sel_info = i_wb_info[w_sel_idx];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and capture decision. External flush beats everything except
  // an in-flight squash pulse; head match beats a same-cycle replacement.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    unique case (r_state)
      StIdle: begin
        // A branch captured while already at head is matched next cycle.
        if (!i_ext_flush && w_sel_vld) begin
          w_capture   = 1'b1;
          w_state_nxt = StPending;
        end
      end
      StPending: begin
        if (i_ext_flush) begin
          w_state_nxt = StIdle;
        end else if (i_head_commit && (i_head_rob_idx == r_rob_idx)) begin
          w_state_nxt = StSquash;
        end else if (w_sel_vld && rob_is_older(w_sel_info.rob_idx, r_rob_idx)) begin
          w_capture = 1'b1;
        end
      end
      StSquash: begin
        w_state_nxt = i_ext_flush ? StIdle : StDrain;
      end
      StDrain: begin
        if (i_ext_flush || i_restore_done) begin
          w_state_nxt = StIdle;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // Stored mispredicted branch: load on capture, clear on external flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rob_idx <= '0;
      r_taken   <= 1'b0;
      r_npc     <= '0;
    end else if (w_capture) begin
      r_rob_idx <= w_sel_info.rob_idx;
      r_taken   <= w_sel_info.branch_taken;
      r_npc     <= w_sel_info.branch_npc;
    end else if (i_ext_flush) begin
      r_rob_idx <= '0;
      r_taken   <= 1'b0;
      r_npc     <= '0;
    end
  end

  // Status and squash outputs decode directly from state so reset clears them
  // asynchronously; squash payload is forced to zero outside the pulse.
  always_comb begin
    o_squash_vld      = (r_state == StSquash);
    o_mispred_pending = (r_state == StPending);
    o_busy            = (r_state == StSquash) || (r_state == StDrain);
    o_squash_info     = '0;
    if (r_state == StSquash) begin
      o_squash_info.dueToBranch  = 1'b1;
      o_squash_info.branch_taken = r_taken;
      o_squash_info.arch_pc      = r_npc;
    end
  end

`ifdef MISPRED_EARLY_REDIRECT_EN
  logic            r_redirect_vld;
  logic [XLEN-1:0] r_redirect_pc;

  // Early frontend redirect one cycle after a capture. Captures never occur in
  // SQUASH/DRAIN, so the pulse is naturally absent there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_redirect_vld <= 1'b0;
      r_redirect_pc  <= '0;
    end else begin
      r_redirect_vld <= w_capture;
      r_redirect_pc  <= w_capture ? w_sel_info.branch_npc : '0;
    end
  end

  assign o_redirect_vld = r_redirect_vld;
  assign o_redirect_pc  = r_redirect_pc;
`endif

endmodule

// File: tb/tb_mispred_tracker.sv
// Self-checking bench for mispred_tracker: directed scenarios followed by a
// randomized run, all compared against a behavioural model that treats ROB
// indices as a 7-bit wrapping counter and orders them by modular distance.
module tb_mispred_tracker;
  import mispred_tracker_pkg::*;

  localparam int NB      = 2;
  localparam int MIdle   = 0;
  localparam int MPend   = 1;
  localparam int MSquash = 2;
  localparam int MDrain  = 3;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic          [NB-1:0] wb_vld;
  branchwbInfo_t [NB-1:0] wb_info;
  logic                   head_commit;
  robIdx_t                head_idx;
  logic                   ext_flush;
  logic                   restore_done;
  logic                   squash_vld;
  squashInfo_t            squash_info;
  logic                   pending;
  logic                   busy;
`ifdef MISPRED_EARLY_REDIRECT_EN
  logic                   redir_vld;
  logic [XLEN-1:0]        redir_pc;
  bit                     m_redir;
  logic [XLEN-1:0]        m_redir_pc;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int              m_mode;
  int              m_rob;
  bit              m_taken;
  logic [XLEN-1:0] m_npc;

  always #5 clk = ~clk;

  mispred_tracker #(
    .NUM_BRU   (NB),
    .ROB_DEPTH (64)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_wb_vld          (wb_vld),
    .i_wb_info         (wb_info),
    .i_head_commit     (head_commit),
    .i_head_rob_idx    (head_idx),
    .i_ext_flush       (ext_flush),
    .i_restore_done    (restore_done),
    .o_squash_vld      (squash_vld),
    .o_squash_info     (squash_info),
    .o_mispred_pending (pending),
    .o_busy            (busy)
`ifdef MISPRED_EARLY_REDIRECT_EN
    ,
    .o_redirect_vld    (redir_vld),
    .o_redirect_pc     (redir_pc)
`endif
  );

  function automatic int full(robIdx_t r);
    return int'({r.flg, r.idx});
  endfunction

  function automatic robIdx_t mk(int v);
    logic [6:0] b;
    b = v[6:0];
    return robIdx_t'(b);
  endfunction

  // a older than b: b lies 1..63 steps ahead of a on the 128-entry ring.
  function automatic bit older(int a, int b);
    int d;
    d = (b - a + 128) % 128;
    return (d >= 1) && (d <= 63);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    squashInfo_t exp_si;
    exp_si = '0;
    if (m_mode == MSquash) begin
      exp_si.dueToBranch  = 1'b1;
      exp_si.branch_taken = m_taken;
      exp_si.arch_pc      = m_npc;
    end
    check({tag, ".squash_vld"}, 64'(squash_vld), 64'(m_mode == MSquash));
    check({tag, ".squash_info"}, 64'(squash_info), 64'(exp_si));
    check({tag, ".pending"}, 64'(pending), 64'(m_mode == MPend));
    check({tag, ".busy"}, 64'(busy), 64'((m_mode == MSquash) || (m_mode == MDrain)));
`ifdef MISPRED_EARLY_REDIRECT_EN
    check({tag, ".redir_vld"}, 64'(redir_vld), 64'(m_redir));
    check({tag, ".redir_pc"}, 64'(redir_pc), 64'(m_redir_pc));
`endif
  endtask

  task automatic clear_inputs();
    wb_vld       = '0;
    wb_info      = '0;
    head_commit  = 1'b0;
    head_idx     = '0;
    ext_flush    = 1'b0;
    restore_done = 1'b0;
  endtask

  task automatic set_wb(input int p, input int rob, input bit mis, input bit tk,
                        input logic [XLEN-1:0] npc);
    wb_vld[p]                  = 1'b1;
    wb_info[p].rob_idx         = mk(rob);
    wb_info[p].has_mispred     = mis;
    wb_info[p].branch_taken    = tk;
    wb_info[p].branch_npc      = npc;
  endtask

  task automatic commit(input int rob);
    head_commit = 1'b1;
    head_idx    = mk(rob);
  endtask

  // Advance one clock: predict from current inputs, then compare after the edge.
  task automatic cycle(input string tag);
    int              best;
    bit              any;
    bit              cap;
    int              nm;
    bit              c_taken;
    logic [XLEN-1:0] c_npc;
    best = 0; any = 1'b0; cap = 1'b0; c_taken = 1'b0; c_npc = '0;
    for (int p = 0; p < NB; p++) begin
      if (wb_vld[p] && wb_info[p].has_mispred) begin
        if (!any || older(full(wb_info[p].rob_idx), best)) begin
          best    = full(wb_info[p].rob_idx);
          c_taken = wb_info[p].branch_taken;
          c_npc   = wb_info[p].branch_npc;
          any     = 1'b1;
        end
      end
    end
    nm = m_mode;
    case (m_mode)
      MIdle: if (!ext_flush && any) begin nm = MPend; cap = 1'b1; end
      MPend: begin
        if (ext_flush) nm = MIdle;
        else if (head_commit && full(head_idx) == m_rob) nm = MSquash;
        else if (any && older(best, m_rob)) cap = 1'b1;
      end
      MSquash: nm = ext_flush ? MIdle : MDrain;
      default: if (ext_flush || restore_done) nm = MIdle;
    endcase
    @(posedge clk);
    #1;
    m_mode = nm;
    if (cap) begin
      m_rob = best; m_taken = c_taken; m_npc = c_npc;
    end
`ifdef MISPRED_EARLY_REDIRECT_EN
    m_redir    = cap;
    m_redir_pc = cap ? c_npc : '0;
`endif
    compare_all(tag);
  endtask

  task automatic finish_drain(input string tag);
    clear_inputs();
    cycle({tag, ".drain"});
    restore_done = 1'b1;
    cycle({tag, ".restore"});
    clear_inputs();
  endtask

  initial begin
    int h;
    clear_inputs();
    m_mode = MIdle; m_rob = 0; m_taken = 1'b0; m_npc = '0;
`ifdef MISPRED_EARLY_REDIRECT_EN
    m_redir = 1'b0; m_redir_pc = '0;
`endif
    // Reset state.
    @(posedge clk); @(posedge clk); #1;
    compare_all("reset");
    rst_n = 1'b1;
    cycle("idle0");

    // Single mispredict, squash on head commit, drain until restore.
    set_wb(0, 5, 1'b1, 1'b1, 32'h8000_0100);
    cycle("s1.cap");
    clear_inputs();
    cycle("s1.hold");
    commit(5);
    cycle("s1.commit");
    check("s1.pulse", 64'(squash_vld), 64'd1);
    check("s1.arch_pc", 64'(squash_info.arch_pc), 64'h8000_0100);
    check("s1.taken", 64'(squash_info.branch_taken), 64'd1);
    clear_inputs();
    cycle("s1.drain0");
    check("s1.busy", 64'(busy), 64'd1);
    finish_drain("s1");
    check("s1.idle", 64'(pending | busy), 64'd0);

    // Two BRUs same cycle: oldest wins; commit of the younger does nothing.
    set_wb(0, 9, 1'b1, 1'b0, 32'h0000_0900);
    set_wb(1, 3, 1'b1, 1'b1, 32'h0000_0300);
    cycle("s2.cap");
    clear_inputs();
    commit(9);
    cycle("s2.commit9");
    check("s2.no_squash", 64'(squash_vld), 64'd0);
    commit(3);
    cycle("s2.commit3");
    check("s2.arch_pc", 64'(squash_info.arch_pc), 64'h0000_0300);
    finish_drain("s2");

    // Wrap: {1,2} replaced by older {0,62}.
    set_wb(0, 66, 1'b1, 1'b0, 32'h1000_0066);
    cycle("s3a.cap");
    set_wb(1, 62, 1'b1, 1'b1, 32'h1000_0062);
    cycle("s3a.repl");
    clear_inputs();
    commit(62);
    cycle("s3a.commit");
    check("s3a.arch_pc", 64'(squash_info.arch_pc), 64'h1000_0062);
    finish_drain("s3a");

    // Wrap: {1,2} replaced by {1,1}; {1,4} dropped; non-mispred ignored.
    set_wb(0, 66, 1'b1, 1'b0, 32'h1000_0066);
    cycle("s3b.cap");
    set_wb(0, 65, 1'b1, 1'b1, 32'h1000_0065);
    cycle("s3b.repl");
    set_wb(0, 68, 1'b1, 1'b0, 32'h1000_0068);
    set_wb(1, 64, 1'b0, 1'b0, 32'h1000_0064);
    cycle("s3b.drop");
    clear_inputs();
    commit(65);
    cycle("s3b.commit");
    check("s3b.arch_pc", 64'(squash_info.arch_pc), 64'h1000_0065);
    finish_drain("s3b");

    // External flush while pending: back to idle, never a squash.
    set_wb(0, 20, 1'b1, 1'b1, 32'h0000_2000);
    cycle("s4.cap");
    clear_inputs();
    ext_flush = 1'b1;
    cycle("s4.flush");
    check("s4.pending", 64'(pending), 64'd0);
    clear_inputs();
    commit(20);
    cycle("s4.commit");
    check("s4.no_squash", 64'(squash_vld), 64'd0);

    // Mispredict during drain ignored.
    set_wb(0, 30, 1'b1, 1'b0, 32'h0000_3000);
    cycle("s5.cap");
    clear_inputs();
    commit(30);
    cycle("s5.commit");
    clear_inputs();
    set_wb(0, 31, 1'b1, 1'b0, 32'h0000_3100);
    cycle("s5.drain_wb");
    clear_inputs();
    restore_done = 1'b1;
    cycle("s5.restore");
    clear_inputs();
    cycle("s5.idle");
    check("s5.pending", 64'(pending), 64'd0);

    // Captured branch already at head: capture only, match next cycle.
    set_wb(0, 40, 1'b1, 1'b1, 32'h0000_4000);
    commit(40);
    cycle("s6.cap_at_head");
    check("s6.no_squash", 64'(squash_vld), 64'd0);
    clear_inputs();
    commit(40);
    cycle("s6.commit");
    // Flush during the squash pulse: pulse done, then idle rather than drain.
    clear_inputs();
    ext_flush = 1'b1;
    cycle("s6.flush_in_squash");
    check("s6.busy", 64'(busy), 64'd0);
    clear_inputs();

    // Randomized traffic within a 32-entry window ahead of the head pointer.
    h = 0;
    for (int n = 0; n < 600; n++) begin
      int  o0;
      int  o1;
      bit  at_head;
      clear_inputs();
      o0 = int'($urandom_range(31));
      o1 = int'($urandom_range(31));
      if (o1 == o0) o1 = (o0 + 1) % 32;
      if ($urandom_range(1) == 1)
        set_wb(0, (h + o0) % 128, $urandom_range(2) == 0, 1'($urandom_range(1)), $urandom());
      if ($urandom_range(1) == 1)
        set_wb(1, (h + o1) % 128, $urandom_range(2) == 0, 1'($urandom_range(1)), $urandom());
      at_head = 1'b0;
      for (int p = 0; p < NB; p++)
        if (wb_vld[p] && wb_info[p].has_mispred && full(wb_info[p].rob_idx) == h) at_head = 1'b1;
      if (m_mode == MPend && $urandom_range(3) == 0) begin
        h = m_rob;
        commit(h);
        h = (h + 1) % 128;
      end else if ((m_mode == MPend || (m_mode == MIdle && !at_head)) &&
                   $urandom_range(1) == 1) begin
        commit(h);
        h = (h + 1) % 128;
      end
      ext_flush    = ($urandom_range(15) == 0);
      restore_done = (m_mode == MDrain) ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
      cycle("rand");
    end
    clear_inputs();

    // Asynchronous reset during the squash pulse.
    set_wb(1, 50, 1'b1, 1'b1, 32'h0000_5000);
    cycle("s7.cap");
    clear_inputs();
    commit(50);
    cycle("s7.commit");
    clear_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    m_mode = MIdle;
`ifdef MISPRED_EARLY_REDIRECT_EN
    m_redir = 1'b0; m_redir_pc = '0;
`endif
    check("s7.rst_vld", 64'(squash_vld), 64'd0);
    check("s7.rst_info", 64'(squash_info), 64'd0);
    check("s7.rst_busy", 64'(busy), 64'd0);
    compare_all("s7.rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle("s7.after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
